// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out converter with a one-word holding
//                register and valid/ready handshakes on both sides. Words
//                queued while a word is shifting follow it with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  load,
   output logic                  ready,
   output logic                  ser_out,
   output logic                  ser_valid,
   input  logic                  ser_ready,
   output logic                  ser_last,
   output logic                  busy
);

   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [0:0]    c_IDLE     = 1'b0;
   localparam logic [0:0]    c_SHIFT    = 1'b1;
   localparam logic [CW-1:0] c_CNT_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

   logic [0:0]            r_state;
   logic [DATA_WIDTH-1:0] r_sr;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_hr;
   logic                  r_hf;

   logic                  w_accept;
   logic                  w_beat;
   logic                  w_at_last;
   logic [DATA_WIDTH-1:0] w_sr_shifted;
   logic                  w_sr_head;

   // The output end of the shift register depends on bit order; the shift
   // always moves the next bit toward that end and fills with zero.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sr_shifted = {r_sr[DATA_WIDTH-2:0], 1'b0};
         assign w_sr_head    = r_sr[DATA_WIDTH-1];
      end else begin : g_lsb_first
         assign w_sr_shifted = {1'b0, r_sr[DATA_WIDTH-1:1]};
         assign w_sr_head    = r_sr[0];
      end
   endgenerate

   // Handshake qualifiers and outputs, all derived from registered state.
   always_comb begin
      ready     = ~r_hf;
      w_accept  = load & ~r_hf;
      w_beat    = (r_state == c_SHIFT) & ser_ready;
      w_at_last = (r_cnt == c_CNT_LAST);
      ser_valid = (r_state == c_SHIFT);
      ser_last  = (r_state == c_SHIFT) & w_at_last;
      ser_out   = w_sr_head;
      busy      = (r_state == c_SHIFT) | r_hf;
   end

   // State machine, shift register, bit counter and holding register.
   // SR is zeroed on entry to IDLE so ser_out reads 0 whenever nothing is
   // being sent.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= c_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_hr    <= '0;
         r_hf    <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_sr    <= data_in;
                  r_cnt   <= '0;
                  r_state <= c_SHIFT;
               end
            end
            c_SHIFT: begin
               if (w_beat && w_at_last) begin
                  // Final beat: queued word first, then a same-cycle word,
                  // otherwise the line goes idle.
                  if (r_hf) begin
                     r_sr  <= r_hr;
                     r_cnt <= '0;
                     r_hr  <= '0;
                     r_hf  <= 1'b0;
                  end else if (w_accept) begin
                     r_sr  <= data_in;
                     r_cnt <= '0;
                  end else begin
                     r_sr    <= '0;
                     r_cnt   <= '0;
                     r_state <= c_IDLE;
                  end
               end else begin
                  if (w_beat) begin
                     r_sr  <= w_sr_shifted;
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
                  if (w_accept) begin
                     r_hr <= data_in;
                     r_hf <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Two instances share
//                all inputs: one MSB-first, one LSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

   typedef struct {
      logic [15:0] data;
      logic [15:0] msb_seq;   // expected bits in send order, bit 15 first
      logic [15:0] lsb_seq;
   } vec_t;

   logic        clk;
   logic        clear;
   logic [15:0] data_in;
   logic        load;
   logic        ser_ready;

   logic        ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
   logic        ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

   int          n_checks;
   int          n_errors;

   vec_t        vecs [5];

   piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
      .clk       (clk),
      .clear     (clear),
      .data_in   (data_in),
      .load      (load),
      .ready     (ready_m),
      .ser_out   (ser_out_m),
      .ser_valid (ser_valid_m),
      .ser_ready (ser_ready),
      .ser_last  (ser_last_m),
      .busy      (busy_m)
   );

   piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
      .clk       (clk),
      .clear     (clear),
      .data_in   (data_in),
      .load      (load),
      .ready     (ready_l),
      .ser_out   (ser_out_l),
      .ser_valid (ser_valid_l),
      .ser_ready (ser_ready),
      .ser_last  (ser_last_l),
      .busy      (busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Outputs of both instances for bit i of a word in flight.
   task automatic check_bit(input int i, input logic [15:0] em, input logic [15:0] el);
      chk($sformatf("ser_valid_m[%0d]", i), 64'(ser_valid_m), 64'd1);
      chk($sformatf("ser_valid_l[%0d]", i), 64'(ser_valid_l), 64'd1);
      chk($sformatf("ser_out_m[%0d]", i), 64'(ser_out_m), 64'(em[15-i]));
      chk($sformatf("ser_out_l[%0d]", i), 64'(ser_out_l), 64'(el[15-i]));
      chk($sformatf("ser_last_m[%0d]", i), 64'(ser_last_m), 64'(i == 15));
      chk($sformatf("ser_last_l[%0d]", i), 64'(ser_last_l), 64'(i == 15));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, 64'(ready_m), 64'd1);
      chk({tag, "_ser_valid_m"}, 64'(ser_valid_m), 64'd0);
      chk({tag, "_ser_valid_l"}, 64'(ser_valid_l), 64'd0);
      chk({tag, "_ser_out"}, 64'(ser_out_m), 64'd0);
      chk({tag, "_ser_last"}, 64'(ser_last_m), 64'd0);
      chk({tag, "_busy_m"}, 64'(busy_m), 64'd0);
      chk({tag, "_busy_l"}, 64'(busy_l), 64'd0);
   endtask

   // Called at a negedge while idle; returns at the negedge showing bit 0.
   task automatic start_word(input logic [15:0] d);
      chk("accept_ready", 64'(ready_m), 64'd1);
      load    = 1'b1;
      data_in = d;
      @(negedge clk);
      load    = 1'b0;
   endtask

   initial begin
      int b;
      int stalls;

      n_checks  = 0;
      n_errors  = 0;
      vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
      vecs[1] = '{16'h0001, 16'h0001, 16'h8000};
      vecs[2] = '{16'h00FF, 16'h00FF, 16'hFF00};
      vecs[3] = '{16'h8001, 16'h8001, 16'h8001};
      vecs[4] = '{16'h1234, 16'h1234, 16'h2C48};

      clear     = 1'b1;
      load      = 1'b0;
      data_in   = 16'h0;
      ser_ready = 1'b1;
      @(negedge clk);
      check_idle("reset");
      clear = 1'b0;
      @(negedge clk);

      // Single words, continuous ser_ready, both bit orders.
      for (int v = 0; v < 5; v++) begin
         start_word(vecs[v].data);
         for (int i = 0; i < 16; i++) begin
            check_bit(i, vecs[v].msb_seq, vecs[v].lsb_seq);
            @(negedge clk);
         end
         check_idle($sformatf("after_vec%0d", v));
      end

      // Back-to-back: FFFF then 0000 queued in the holding register.
      start_word(16'hFFFF);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("b2b_valid[%0d]", i), 64'(ser_valid_m), 64'd1);
         chk($sformatf("b2b_out[%0d]", i), 64'(ser_out_m), 64'(i < 16));
         chk($sformatf("b2b_last[%0d]", i), 64'(ser_last_m), 64'(i == 15 || i == 31));
         chk($sformatf("b2b_ready[%0d]", i), 64'(ready_m), 64'(i == 0 || i >= 16));
         if (i >= 1 && i <= 15)
            chk($sformatf("b2b_busy[%0d]", i), 64'(busy_m), 64'd1);
         if (i == 0) begin
            load    = 1'b1;
            data_in = 16'h0000;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      check_idle("after_b2b");

      // Back-pressure: 5 stalled cycles while bit 7 of 8001 is presented.
      start_word(16'h8001);
      b      = 0;
      stalls = 0;
      while (b < 16) begin
         chk($sformatf("bp_valid[%0d]", b), 64'(ser_valid_m), 64'd1);
         chk($sformatf("bp_out_m[%0d]", b), 64'(ser_out_m), 64'(b == 0 || b == 15));
         chk($sformatf("bp_out_l[%0d]", b), 64'(ser_out_l), 64'(b == 0 || b == 15));
         chk($sformatf("bp_last[%0d]", b), 64'(ser_last_m), 64'(b == 15));
         if (b == 7 && stalls < 5) begin
            ser_ready = 1'b0;
            stalls++;
         end else begin
            ser_ready = 1'b1;
            b++;
         end
         @(negedge clk);
      end
      ser_ready = 1'b1;
      check_idle("after_bp");

      // Final-beat collision with HF=0: next word follows with no bubble.
      start_word(16'hF0F0);
      for (int i = 0; i < 16; i++) begin
         check_bit(i, 16'hF0F0, 16'h0F0F);
         if (i == 15) begin
            chk("coll_ready", 64'(ready_m), 64'd1);
            load    = 1'b1;
            data_in = 16'h1234;
         end
         @(negedge clk);
         load = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         check_bit(i, 16'h1234, 16'h2C48);
         @(negedge clk);
      end
      check_idle("after_coll");

      // Final-beat collision with HF=1: the new word is refused.
      start_word(16'h00FF);
      for (int i = 0; i < 16; i++) begin
         check_bit(i, 16'h00FF, 16'hFF00);
         if (i == 3) begin
            load    = 1'b1;
            data_in = 16'h5555;
         end
         if (i == 15) begin
            chk("coll_hf_ready", 64'(ready_m), 64'd0);
            chk("coll_hf_busy", 64'(busy_m), 64'd1);
            load    = 1'b1;
            data_in = 16'h1234;
         end
         @(negedge clk);
         load = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         check_bit(i, 16'h5555, 16'hAAAA);
         @(negedge clk);
      end
      check_idle("after_coll_hf");

      // Clear mid-word with HF=1, load asserted in the same cycle.
      start_word(16'hA5C3);
      for (int i = 0; i < 6; i++) begin
         check_bit(i, 16'hA5C3, 16'hC3A5);
         if (i == 3) begin
            load    = 1'b1;
            data_in = 16'h1111;
         end else if (i == 5) begin
            chk("pre_clear_ready", 64'(ready_m), 64'd0);
            clear   = 1'b1;
            load    = 1'b1;
            data_in = 16'hBEEF;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      clear = 1'b0;
      load  = 1'b0;
      check_idle("after_clear");
      @(negedge clk);
      check_idle("after_clear2");
      start_word(16'h00FF);
      for (int i = 0; i < 16; i++) begin
         check_bit(i, 16'h00FF, 16'hFF00);
         @(negedge clk);
      end
      check_idle("after_fresh");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, parallel word width; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit DATA_WIDTH-1 serialized first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 data_in  input  DATA_WIDTH  parallel word to serialize.
REQ-006 load  input  1  data_in valid; word accepted on a cycle where load=1 and ready=1.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_out holds a valid bit.
REQ-010 ser_ready  input  1  downstream consumes ser_out on a cycle where ser_valid=1 and ser_ready=1 (a "beat").
REQ-011 ser_last  output  1  high with the final bit of each word.
REQ-012 busy  output  1  high when the shift register or the holding register holds data.

Function
REQ-013 Storage:
- shift register SR (DATA_WIDTH bits)
- bit counter CNT (0..DATA_WIDTH-1, width clog2(DATA_WIDTH))
- holding register HR (DATA_WIDTH bits) with flag HF
REQ-014 Two states: IDLE (SR empty) and SHIFT (SR holds a word being sent).
REQ-015 ready = !HF, combinational from registered state only; it never depends on load or ser_ready.
REQ-016 IDLE:
- ser_valid=0; ser_last=0
- accepted word loads SR, CNT=0, next state SHIFT
- HF is always 0 in IDLE
REQ-017 SHIFT:
- ser_valid=1
- ser_out = SR[DATA_WIDTH-1] if MSB_FIRST, else SR[0]
- ser_last = (CNT == DATA_WIDTH-1)
REQ-018 SHIFT beat with CNT < DATA_WIDTH-1: SR shifts one place toward the output end (zero fill) and CNT increments.
REQ-019 SHIFT without a beat: SR, CNT, ser_out and ser_last hold their values; ser_valid stays 1 (no bit is ever withdrawn).
REQ-020 Final beat (CNT = DATA_WIDTH-1), in priority order:
- (a) HF=1: HR moves to SR, CNT=0, HF clears, stay SHIFT.
- (b) HF=0 and a word is accepted the same cycle: that word loads SR directly, CNT=0, stay SHIFT (no bubble).
- (c) otherwise: go to IDLE.
REQ-021 In SHIFT, a word accepted outside case 020(b) loads HR and sets HF.
REQ-022 Simultaneous final beat, HF=1 and load=1: ready=0, so the new word is not accepted; HR moves to SR per 020(a).
REQ-023 Throughput:
- back-to-back words produce DATA_WIDTH consecutive beats per word with no idle cycle while ser_ready=1
- latency from acceptance in IDLE to first ser_valid is 1 cycle
REQ-024 busy = (state == SHIFT) | HF.
REQ-025 load while ready=0 is ignored; data_in is not sampled.

Reset
REQ-026 clear=1 at a clock edge, in any state and mid-word, forces:
- state=IDLE, SR=0, CNT=0, HR=0, HF=0
- so ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0
REQ-027 clear has priority over load and ser_ready in the same cycle; no word is accepted and no beat counts.
REQ-028 The partial word in flight at reset is discarded; no bit of it appears after reset.

Verification
REQ-029 Single word, MSB_FIRST=1, data_in=16'hA5C3, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 consecutive cycles starting 1 cycle after accept; ser_last only on the 16th; then IDLE, busy=0.
REQ-030 MSB_FIRST=0, word 16'h0001 -> first bit 1, then fifteen 0s.
REQ-031 Back-to-back: 16'hFFFF accepted, then 16'h0000 accepted while shifting -> HF=1, ready=0, then 32 consecutive beats (16 ones, 16 zeros) with no gap; ready returns to 1 the cycle after the first word's last beat.
REQ-032 Back-pressure: ser_ready=0 for 5 cycles at bit 7 of 16'h8001 -> ser_out, ser_last and CNT frozen, ser_valid=1 throughout; resume yields the remaining 9 bits unchanged.
REQ-033 Final-beat collision: HF=0, load=1 with 16'h1234 on the last beat of the previous word -> 16'h1234 begins on the next cycle with no bubble; with HF=1 the same load is refused (ready=0).
REQ-034 Reset mid-word: clear=1 at bit 5 with HF=1 -> next cycle ready=1, ser_valid=0, busy=0; a fresh word 16'h00FF then serializes from bit 0 correctly.
